// File: rtl/pe_urate.sv
// rtl/pe_urate.sv - unary-rate systolic PE with per-operation MAC length
// Optional feature macro: PE_URATE_SAT_EN (saturating DONE-stage partial-sum add).
module pe_urate #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 16,
  parameter int CWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CWIDTH-1:0]        mac_len,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     en_w,
  input  logic                     clr_w,
  input  logic                     en_o,
  input  logic                     clr_o,
  input  logic                     ifm_sign,
  input  logic                     ifm_bit,
  input  logic                     wght_sign,
  input  logic [IWIDTH-2:0]        wght_abs,
  input  logic [IWIDTH-2:0]        randW,
  input  logic signed [OWIDTH-1:0] ofm,
  output logic                     start_d,
  output logic [CWIDTH-1:0]        mac_len_d,
  output logic                     en_i_d,
  output logic                     clr_i_d,
  output logic                     en_w_d,
  output logic                     clr_w_d,
  output logic                     en_o_d,
  output logic                     clr_o_d,
  output logic [IWIDTH-2:0]        randW_d,
  output logic                     ifm_sign_d,
  output logic                     ifm_bit_d,
  output logic                     wght_sign_d,
  output logic [IWIDTH-2:0]        wght_abs_d,
  output logic signed [OWIDTH-1:0] ofm_d,
  output logic                     ofm_vld
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic signed [OWIDTH-1:0] ONE = OWIDTH'(1);

  state_t                   state;
  logic [CWIDTH-1:0]        cnt;
  logic [CWIDTH-1:0]        len_q;
  logic signed [OWIDTH-1:0] acc;
  logic signed [OWIDTH-1:0] sum;
  logic                     prod;
  logic                     neg;

  // Comparator-based unary multiply against the registered weight magnitude.
  assign prod = ifm_bit_d & (randW < wght_abs_d);
  assign neg  = ifm_sign_d ^ wght_sign_d;

`ifdef PE_URATE_SAT_EN
  logic [OWIDTH:0] sum_wide;
  assign sum_wide = {ofm[OWIDTH-1], ofm} + {acc[OWIDTH-1], acc};
  always_comb begin
    sum = sum_wide[OWIDTH-1:0];
    if (sum_wide[OWIDTH] != sum_wide[OWIDTH-1])
      sum = sum_wide[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
  end
`else
  assign sum = ofm + acc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_d     <= 1'b0;
      mac_len_d   <= '0;
      en_i_d      <= 1'b0;
      clr_i_d     <= 1'b0;
      en_w_d      <= 1'b0;
      clr_w_d     <= 1'b0;
      en_o_d      <= 1'b0;
      clr_o_d     <= 1'b0;
      randW_d     <= '0;
      ifm_sign_d  <= 1'b0;
      ifm_bit_d   <= 1'b0;
      wght_sign_d <= 1'b0;
      wght_abs_d  <= '0;
    end else begin
      start_d   <= start;
      mac_len_d <= mac_len;
      en_i_d    <= en_i;
      clr_i_d   <= clr_i;
      en_w_d    <= en_w;
      clr_w_d   <= clr_w;
      en_o_d    <= en_o;
      clr_o_d   <= clr_o;
      randW_d   <= randW;
      if (clr_i) begin
        ifm_sign_d <= 1'b0;
        ifm_bit_d  <= 1'b0;
      end else if (en_i) begin
        ifm_sign_d <= ifm_sign;
        ifm_bit_d  <= ifm_bit;
      end
      if (clr_w) begin
        wght_sign_d <= 1'b0;
        wght_abs_d  <= '0;
      end else if (en_w) begin
        wght_sign_d <= wght_sign;
        wght_abs_d  <= wght_abs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      acc     <= '0;
      ofm_d   <= '0;
      ofm_vld <= 1'b0;
    end else begin
      ofm_vld <= 1'b0;
      if (clr_o)
        acc <= '0;
      else if (state == RUN && en_o && prod)
        acc <= neg ? acc - ONE : acc + ONE;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            len_q <= mac_len;
            // A zero-length MAC skips RUN and just passes the upstream sum.
            state <= (mac_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          cnt <= cnt + CWIDTH'(1);
          if (cnt == len_q - CWIDTH'(1))
            state <= DONE;
        end
        DONE: begin
          ofm_d   <= sum;
          ofm_vld <= 1'b1;
          acc     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pe_urate.md
# pe_urate

Parametrised unary-rate processing element for the systolic array, and the successor of the fixed-length inner PE. Each MAC takes a programmable number of bitstream cycles, set per operation by `mac_len`, which allows early termination at lower accuracy. The block holds a weight register and an input-bit register, does a comparator-based unary multiply and a signed up/down accumulate, and sequences itself with an internal counter and FSM. All control and data are forwarded one cycle downstream to the next PE in the row/column.

## Interface
Parameters:
- `IWIDTH`, 8, operand width including sign; magnitude is `IWIDTH-1` bits.
- `OWIDTH`, 16, signed partial-sum width.
- `CWIDTH`, 8, MAC-length counter width; must satisfy `CWIDTH < OWIDTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a MAC (accepted only in IDLE).
- `mac_len` in CWIDTH: bitstream cycles for this MAC; sampled on the accepted `start`.
- `en_i`, `clr_i` in 1: input-bit register enable and clear.
- `en_w`, `clr_w` in 1: weight register enable and clear.
- `en_o`, `clr_o` in 1: accumulator enable and clear.
- `ifm_sign`, `ifm_bit` in 1: input sign and input unary bit.
- `wght_sign` in 1: weight sign.
- `wght_abs` in IWIDTH-1: weight magnitude.
- `randW` in IWIDTH-1: random number used for weight bitstream generation.
- `ofm` in OWIDTH signed: upstream partial sum.
- Forwarded outputs, each the one-cycle-delayed copy of its input: `start_d`, `mac_len_d`, `en_i_d`, `clr_i_d`, `en_w_d`, `clr_w_d`, `en_o_d`, `clr_o_d`, `randW_d`.
- Register outputs: `ifm_sign_d`, `ifm_bit_d`, `wght_sign_d`, `wght_abs_d`.
- `ofm_d` out OWIDTH signed: resulting partial sum.
- `ofm_vld` out 1: one-cycle pulse, asserted when `ofm_d` is updated.

## Operation
- **Input register:**
  - `clr_i` has priority and zeroes `ifm_sign_d` and `ifm_bit_d`.
  - Otherwise `en_i` loads `ifm_sign` and `ifm_bit`; else the register holds.
- **Weight register:** same rule applied to `wght_sign` and `wght_abs`.
- **Product bit:** `prod = ifm_bit_d & (randW < wght_abs_d)`, unsigned compare, combinational.
- **Product sign:** `neg = ifm_sign_d ^ wght_sign_d`.
- **Accumulator:** `acc`, OWIDTH signed.
  - `clr_o` has priority and sets `acc` to 0.
  - Else, in RUN with `en_o` and `prod` both high, `acc` changes by -1 if `neg`, otherwise by +1.
  - `acc` is otherwise held.
- **FSM states IDLE, RUN, DONE:**
  - IDLE → RUN on `start` with `mac_len != 0`; `cnt` is set to 0 and `len_q` is set to `mac_len`.
  - IDLE → DONE on `start` with `mac_len == 0`; this is a pass-through and `acc` is not updated.
  - RUN: `cnt` increments every cycle, whether or not `en_o` is high. When `cnt == len_q-1`, the FSM goes to DONE after that cycle's accumulate.
  - DONE: `ofm_d <= ofm + acc`, `ofm_vld <= 1`, `acc <= 0`, then IDLE.
  - `start` is ignored in RUN and DONE; no queuing.
- **Mid-run events:**
  - `clr_o` during RUN clears `acc`; `cnt` continues.
  - `clr_w`/`en_w` during RUN take effect immediately (user responsibility).
- **Outside DONE:** `ofm_d` holds its value and `ofm_vld` = 0.

## Timing
- **Reset** (rst_n low at a rising edge):
  - FSM goes to IDLE.
  - `cnt`, `len_q` and `acc` are 0.
  - Every output is 0, including `ofm_d` and `ofm_vld`.
- **Reset mid-RUN** aborts the MAC with no `ofm_vld`.
- **Forwarding:** all `_d` control and forwarded outputs lag their inputs by exactly 1 cycle, providing the systolic skew. `start_d` and `mac_len_d` lag in lockstep with the forwarded data.
- **Latency:** `start` accepted at edge 0 with `mac_len = N > 0`:
  - RUN accumulates on edges 1..N.
  - DONE at edge N+1 updates `ofm_d` and pulses `ofm_vld`.
  - IDLE again at edge N+2, so the next `start` can be accepted at edge N+2.
  - Throughput is one MAC per N+2 cycles.
- **`mac_len = 0`:** `ofm_vld` pulses at edge 1 with `ofm_d = ofm`, sampled at edge 1.
- **Sampling:** `ofm` is sampled only in DONE; the upstream PE must present its partial sum there.
- **Accumulator bound:** |acc| ≤ 2^CWIDTH-1, so `acc` itself never overflows.

## Configuration
- **`PE_URATE_SAT_EN` defined:** the DONE addition `ofm + acc` saturates to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
- **`PE_URATE_SAT_EN` undefined:** the addition wraps modulo 2^OWIDTH, in two's complement.
- The macro has no other effect.

## Test plan
- **Reset:** rst_n low for 2 cycles with random inputs → all outputs 0 and FSM in IDLE; rst_n low mid-RUN → no `ofm_vld` and `acc = 0`.
- **Positive MAC:** `wght_abs = 64`, both signs 0, `ifm_bit = 1`, `randW` sweeps 0..127, `mac_len = 128`, `ofm = 100`, `en_o = 1` → `ofm_vld` at cycle 129 after start with `ofm_d = 164`.
- **Negative and early termination:** `wght_sign = 1`, `wght_abs = 127`, `ifm_bit = 1`, `randW = 0` constant, `mac_len = 16`, `ofm = 0` → `ofm_d = -16`, `ofm_vld` 17 cycles after start.
- **Edge cases:**
  - `mac_len = 0`, `ofm = -5` → `ofm_vld` next cycle with `ofm_d = -5`.
  - `start` reasserted during RUN → ignored, and exactly one `ofm_vld` per accepted start.
- **Saturation:** `ofm = 32760`, `acc = +16` → `ofm_d = 32767` with the macro defined, `-32760` without.
- **Forwarding and clears:**
  - All `_d` outputs equal their inputs delayed by 1 cycle over 200 random cycles.
  - `clr_o` at RUN cycle 5 of 10, with `prod = 1` throughout → `ofm_d = ofm + 5`.
